// File: rtl/dmgplus_cart_reader.sv
// Read-only Game Boy cartridge bus master: turns a one-byte read request into a timed
// SETUP / STROBE / HOLD cycle on the cart pins, with strobe widths set by parameters.
module dmgplus_cart_reader #(
  parameter int SETUP_CYC  = 2,
  parameter int ACCESS_CYC = 4,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk_8m,
  input  logic        rst,
  input  logic [15:0] rom_addr,
  input  logic        rom_rd,
  output logic        rom_bsy,
  output logic [7:0]  rom_data,
  output logic [15:0] cart_a,
  input  logic [7:0]  cart_d_in,
  output logic        cart_rd_n,
  output logic        cart_wr_n,
  output logic        cart_cs_n,
  output logic [1:0]  dbg_state
);

  // Request handshake: rom_rd is a one-cycle pulse accepted only in IDLE; rom_bsy is
  // combinational so the requester sees it high in the very cycle it raised rom_rd.
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3} state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] ACCESS_LD = 4'(ACCESS_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] cart_a_q, cart_a_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic        cart_rd_n_q, cart_rd_n_d;
  logic        strobe_end;

  always_ff @(posedge clk_8m) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cart_a_q    <= 16'h0000;
      rom_data_q  <= 8'h00;
      cart_rd_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cart_a_q    <= cart_a_d;
      rom_data_q  <= rom_data_d;
      cart_rd_n_q <= cart_rd_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rom_rd) begin
          if (SETUP_CYC == 0) begin
            state_d = STROBE;
            cnt_d   = ACCESS_LD;
          end else begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = ACCESS_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          if (HOLD_CYC == 0) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // /RD is registered from the next state so it drops exactly on STROBE entry.
  always_comb begin
    strobe_end  = (state_q == STROBE) && (cnt_q == 4'd0);
    cart_a_d    = ((state_q == IDLE) && rom_rd) ? rom_addr : cart_a_q;
    rom_data_d  = strobe_end ? cart_d_in : rom_data_q;
    cart_rd_n_d = (state_d != STROBE);
    rom_bsy     = rom_rd | (state_q != IDLE);
  end

  assign rom_data  = rom_data_q;
  assign cart_a    = cart_a_q;
  assign cart_rd_n = cart_rd_n_q;
  assign cart_wr_n = 1'b1;
  assign cart_cs_n = 1'b1;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmgplus_cart_reader.sv
// Directed bench for dmgplus_cart_reader: default-timing instance plus a fast-timing
// instance (SETUP 0, ACCESS 1, HOLD 0), each wired to a small combinational cart model.
module tb_dmgplus_cart_reader;

  logic        clk = 1'b0;
  logic        rst;
  int          vectors = 0;
  int          miscompares = 0;

  // default-parameter instance
  logic [15:0] rom_addr, cart_a;
  logic        rom_rd, rom_bsy, cart_rd_n, cart_wr_n, cart_cs_n;
  logic [7:0]  rom_data, cart_d;
  logic [1:0]  dbg_state;

  // fast-parameter instance
  logic [15:0] f_rom_addr, f_cart_a;
  logic        f_rom_rd, f_rom_bsy, f_cart_rd_n, f_cart_wr_n, f_cart_cs_n;
  logic [7:0]  f_rom_data, f_cart_d;
  logic [1:0]  f_dbg_state;

  always #62 clk = ~clk;

  // Cart contents: 0x44 at 0x0100, elsewhere high byte XOR low byte.
  function automatic logic [7:0] cart_byte(input logic [15:0] a);
    if (a == 16'h0100) return 8'h44;
    return a[15:8] ^ a[7:0];
  endfunction

  assign cart_d   = cart_byte(cart_a);
  assign f_cart_d = cart_byte(f_cart_a);

  dmgplus_cart_reader dut (
    .clk_8m(clk), .rst(rst), .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_bsy(rom_bsy),
    .rom_data(rom_data), .cart_a(cart_a), .cart_d_in(cart_d), .cart_rd_n(cart_rd_n),
    .cart_wr_n(cart_wr_n), .cart_cs_n(cart_cs_n), .dbg_state(dbg_state)
  );

  dmgplus_cart_reader #(.SETUP_CYC(0), .ACCESS_CYC(1), .HOLD_CYC(0)) dut_fast (
    .clk_8m(clk), .rst(rst), .rom_addr(f_rom_addr), .rom_rd(f_rom_rd), .rom_bsy(f_rom_bsy),
    .rom_data(f_rom_data), .cart_a(f_cart_a), .cart_d_in(f_cart_d), .cart_rd_n(f_cart_rd_n),
    .cart_wr_n(f_cart_wr_n), .cart_cs_n(f_cart_cs_n), .dbg_state(f_dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int lows;
  int falls;
  logic prev_rd_n;

  initial begin
    rst = 1'b1; rom_rd = 1'b0; rom_addr = 16'h0000;
    f_rom_rd = 1'b0; f_rom_addr = 16'h0000;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_rd_n", {15'd0, cart_rd_n}, 16'd1);
    check("rst_wr_n", {15'd0, cart_wr_n}, 16'd1);
    check("rst_cs_n", {15'd0, cart_cs_n}, 16'd1);
    check("rst_cart_a", cart_a, 16'h0000);
    check("rst_bsy", {15'd0, rom_bsy}, 16'd0);
    check("rst_data", {8'd0, rom_data}, 16'h0000);
    check("rst_fast_bsy", {15'd0, f_rom_bsy}, 16'd0);
    tick();

    // Single read at 0x0100, default timing
    for (int c = 0; c <= 8; c++) begin
      if (c == 0) begin rom_addr = 16'h0100; rom_rd = 1'b1; end
      else begin rom_rd = 1'b0; rom_addr = 16'hFFFF; end
      #1;
      check($sformatf("single_bsy_c%0d", c), {15'd0, rom_bsy}, (c <= 7) ? 16'd1 : 16'd0);
      check($sformatf("single_rdn_c%0d", c), {15'd0, cart_rd_n},
            (c >= 3 && c <= 6) ? 16'd0 : 16'd1);
      if (c >= 1) check($sformatf("single_a_c%0d", c), cart_a, 16'h0100);
      if (c <= 6) check($sformatf("single_data_c%0d", c), {8'd0, rom_data}, 16'h0000);
      if (c == 8) check("single_data_done", {8'd0, rom_data}, 16'h0044);
      tick();
    end
    check("single_a_held", cart_a, 16'h0100);
    check("single_wr_n", {15'd0, cart_wr_n}, 16'd1);
    check("single_cs_n", {15'd0, cart_cs_n}, 16'd1);

    // Busy rejection: second request at cycle 3 is dropped
    lows = 0; falls = 0; prev_rd_n = cart_rd_n;
    for (int c = 0; c <= 8; c++) begin
      rom_rd = (c == 0) || (c == 3);
      rom_addr = (c == 3) ? 16'h5678 : 16'h1234;
      #1;
      if (cart_rd_n == 1'b0) lows++;
      if (prev_rd_n && !cart_rd_n) falls++;
      prev_rd_n = cart_rd_n;
      if (c >= 1) check($sformatf("busy_a_c%0d", c), cart_a, 16'h1234);
      if (c == 8) begin
        check("busy_data", {8'd0, rom_data}, 16'h0026);
        check("busy_bsy_done", {15'd0, rom_bsy}, 16'd0);
        break;
      end
      tick();
    end
    check("busy_low_cycles", 16'(lows), 16'd4);
    check("busy_strobes", 16'(falls), 16'd1);

    // Back-to-back: request in the first idle cycle; old data held until end of strobe
    for (int c = 0; c <= 8; c++) begin
      rom_rd = (c == 0);
      rom_addr = (c == 0) ? 16'h3C81 : 16'h0000;
      #1;
      if (c == 1) check("b2b_a", cart_a, 16'h3C81);
      if (c == 6) check("b2b_data_old", {8'd0, rom_data}, 16'h0026);
      if (c == 7) check("b2b_data_new", {8'd0, rom_data}, 16'h00BD);
      if (c == 8) check("b2b_bsy_done", {15'd0, rom_bsy}, 16'd0);
      tick();
    end

    // rom_rd held high three cycles: exactly one strobe
    lows = 0; falls = 0; prev_rd_n = cart_rd_n;
    for (int c = 0; c <= 9; c++) begin
      rom_rd = (c <= 2);
      rom_addr = 16'h0100 + 16'(c);
      #1;
      if (cart_rd_n == 1'b0) lows++;
      if (prev_rd_n && !cart_rd_n) falls++;
      prev_rd_n = cart_rd_n;
      tick();
    end
    check("held_low_cycles", 16'(lows), 16'd4);
    check("held_strobes", 16'(falls), 16'd1);
    check("held_a", cart_a, 16'h0100);
    check("held_data", {8'd0, rom_data}, 16'h0044);

    // Reset mid-strobe at cycle 4
    for (int c = 0; c <= 5; c++) begin
      rom_rd = (c == 0);
      rom_addr = 16'h1234;
      rst = (c == 4);
      #1;
      if (c == 4) check("mid_rdn_low", {15'd0, cart_rd_n}, 16'd0);
      if (c == 5) begin
        check("mid_rdn", {15'd0, cart_rd_n}, 16'd1);
        check("mid_bsy", {15'd0, rom_bsy}, 16'd0);
        check("mid_data", {8'd0, rom_data}, 16'h0000);
        check("mid_cart_a", cart_a, 16'h0000);
        break;
      end
      tick();
    end
    rst = 1'b0;
    tick();

    // Fast timing: 1-cycle strobe, idle again at cycle 2
    for (int c = 0; c <= 2; c++) begin
      f_rom_rd = (c == 0);
      f_rom_addr = (c == 0) ? 16'h3C81 : 16'h0000;
      #1;
      case (c)
        0: begin
          check("fast_bsy_c0", {15'd0, f_rom_bsy}, 16'd1);
          check("fast_rdn_c0", {15'd0, f_cart_rd_n}, 16'd1);
        end
        1: begin
          check("fast_bsy_c1", {15'd0, f_rom_bsy}, 16'd1);
          check("fast_rdn_c1", {15'd0, f_cart_rd_n}, 16'd0);
          check("fast_a_c1", f_cart_a, 16'h3C81);
        end
        default: begin
          check("fast_bsy_c2", {15'd0, f_rom_bsy}, 16'd0);
          check("fast_rdn_c2", {15'd0, f_cart_rd_n}, 16'd1);
          check("fast_data", {8'd0, f_rom_data}, 16'h00BD);
        end
      endcase
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
